pll_lock_mgr: RTL
=================

# pll_lock_mgr

Reset and lock sequencer that sits beside the PLL wrapper and drives its `pll_rst` and `clkout0_gate` inputs from its `pll_lock` output. It pulses PLL reset, waits for a qualified lock, enables the gated clock, and releases a downstream system reset. On timeout it retries a bounded number of times before latching a fault. It runs on the PLL reference clock, which stays alive while the PLL is unlocked.

## Interface
- `RST_CYCLES`, default 16: width of each `pll_rst` pulse, in cycles (≥1).
- `LOCK_TIMEOUT_CYCLES`, default 50000: cycles to wait for lock after reset before retrying (≥2).
- `LOCK_STABLE_CYCLES`, default 1024: number of consecutive synchronized-lock-high cycles needed to qualify lock (≥1).
- `GATE_DELAY`, default 8: cycles between `clkout0_gate` rising and `sys_rst` release (≥1).
- `MAX_RETRY`, default 7: number of timeouts tolerated before fault (1..255).
- `clkin1`, in, 1: reference clock; the only clock in this block.
- `ext_rst`, in, 1: asynchronous, active-high reset.
- `pll_lock`, in, 1: PLL lock, asynchronous to `clkin1`.
- `soft_rst_req`, in, 1: single-cycle request to restart the sequence.
- `pll_rst`, out, 1: reset to the PLL.
- `clkout0_gate`, out, 1: enable for `clkout0`.
- `sys_rst`, out, 1: active-high downstream reset.
- `pll_ready`, out, 1: PLL is locked and the system is running.
- `pll_fault`, out, 1: retries are exhausted.
- `retry_cnt`, out, 8: number of timeouts since the last successful RUN or the last soft reset.
- `lock_loss_cnt`, out, 8: number of lock losses seen while in RUN; saturates at 255.

## Operation
- `pll_lock` passes through a 2-flop synchronizer to give `lock_s`. The synchronizer flops reset to 0.
- States: RESET, WAIT_LOCK, STABLE, GATE_DLY, RUN, FAULT. A single timer is cleared on every state change.
- RESET:
  - `pll_rst`=1.
  - After `RST_CYCLES` cycles, go to WAIT_LOCK.
- WAIT_LOCK:
  - If `lock_s`=1, go to STABLE.
  - Otherwise, when the timer reaches `LOCK_TIMEOUT_CYCLES`-1, `retry_cnt` increments. If the new value equals `MAX_RETRY`, go to FAULT; otherwise go to RESET.
- STABLE:
  - When `lock_s` has been high for `LOCK_STABLE_CYCLES` consecutive cycles, go to GATE_DLY.
  - If `lock_s`=0, go to WAIT_LOCK with a fresh timeout.
- GATE_DLY:
  - `clkout0_gate`=1.
  - After `GATE_DELAY` cycles, go to RUN.
  - If `lock_s`=0, go to RESET. This does not touch `retry_cnt`.
- RUN:
  - `pll_ready`=1, `sys_rst`=0, `clkout0_gate`=1.
  - `retry_cnt` clears on entry.
  - If `lock_s`=0, `lock_loss_cnt` increments (saturating) and the state goes to RESET.
- FAULT:
  - `pll_rst`=1, `pll_fault`=1, `clkout0_gate`=0, `sys_rst`=1.
  - Leaves only on `soft_rst_req` or `ext_rst`.
- `soft_rst_req`, in any state:
  - Next state is RESET and `retry_cnt` clears.
  - It overrides every same-cycle transition and counter update, except that a lock-loss increment in RUN still occurs.
- `sys_rst`=1 and `pll_ready`=0 in every state except RUN.
- `clkout0_gate`=1 only in GATE_DLY and RUN.

## Timing
- Reset values, while `ext_rst` is high: state=RESET, timer=0, `pll_rst`=1, `clkout0_gate`=0, `sys_rst`=1, `pll_ready`=0, `pll_fault`=0, `retry_cnt`=0, `lock_loss_cnt`=0.
- All outputs are registered and decoded from the next state, so each output changes on the same edge as its state transition.
- Latency from a `pll_lock` edge to `lock_s` is 2 cycles. A lock drop in RUN deasserts `clkout0_gate` and `pll_ready`, and asserts `sys_rst` and `pll_rst`, on the 3rd edge after the drop.
- `pll_rst` high time is exactly `RST_CYCLES` cycles per pulse, including the first pulse after `ext_rst` falls.
- Fastest path to RUN after `ext_rst` falls, with lock already high: `RST_CYCLES` + 1 + `LOCK_STABLE_CYCLES` + `GATE_DELAY` cycles. The +1 is the WAIT_LOCK cycle.
- If `ext_rst` is asserted mid-sequence, all outputs return to their reset values asynchronously. No output glitches high on exit from reset.

## Configuration
- `PLL_LOCK_MGR_LOSS_CNT_EN` defined: the `lock_loss_cnt` counter and its saturating logic are compiled in.
- Not defined: `lock_loss_cnt` is tied to 0, no counter flops exist, and all other behaviour is identical.

## Test plan
Bench parameters for all scenarios: `RST_CYCLES`=4, `LOCK_TIMEOUT_CYCLES`=32, `LOCK_STABLE_CYCLES`=8, `GATE_DELAY`=2, `MAX_RETRY`=2.
- Clean start: release `ext_rst` with `pll_lock`=1 -> `pll_rst` high for 4 cycles, `clkout0_gate` rises 9 cycles later, `sys_rst` falls and `pll_ready` rises 2 cycles after that.
- Lock glitch in STABLE: drop `pll_lock` for 1 cycle after 5 high cycles -> state returns to WAIT_LOCK, `clkout0_gate` stays 0, and a full 8 stable cycles are required again.
- Timeouts to fault: hold `pll_lock`=0 -> two 4-cycle `pll_rst` pulses 32 cycles apart, then `retry_cnt`=2, `pll_fault`=1, and `pll_rst` is held at 1.
- Fault recovery: pulse `soft_rst_req` in FAULT with `pll_lock`=1 -> `pll_fault`=0, `retry_cnt`=0, and a normal sequence reaches RUN.
- Lock loss in RUN, with the macro defined: drop `pll_lock` 3 times -> each drop deasserts `clkout0_gate` on the 3rd edge, and `lock_loss_cnt` reads 3. With the macro undefined, `lock_loss_cnt` stays 0.
- Async reset mid-GATE_DLY: assert `ext_rst` off-edge -> outputs take their reset values immediately, with no wait for a clock edge.

Source files
------------

// File: rtl/pll_lock_mgr.sv
// rtl/pll_lock_mgr.sv - PLL reset/lock sequencer with bounded retry and fault latch.
// Optional lock-loss counter is compiled in when PLL_LOCK_MGR_LOSS_CNT_EN is defined.
module pll_lock_mgr #(
  parameter int RST_CYCLES          = 16,
  parameter int LOCK_TIMEOUT_CYCLES = 50000,
  parameter int LOCK_STABLE_CYCLES  = 1024,
  parameter int GATE_DELAY          = 8,
  parameter int MAX_RETRY           = 7
) (
  input  logic       clkin1,
  input  logic       ext_rst,
  input  logic       pll_lock,
  input  logic       soft_rst_req,
  output logic       pll_rst,
  output logic       clkout0_gate,
  output logic       sys_rst,
  output logic       pll_ready,
  output logic       pll_fault,
  output logic [7:0] retry_cnt,
  output logic [7:0] lock_loss_cnt
);

  typedef enum logic [2:0] {
    S_RESET,
    S_WAIT_LOCK,
    S_STABLE,
    S_GATE_DLY,
    S_RUN,
    S_FAULT
  } state_t;

  localparam logic [31:0] RST_LAST  = 32'(RST_CYCLES - 1);
  localparam logic [31:0] TO_LAST   = 32'(LOCK_TIMEOUT_CYCLES - 1);
  localparam logic [31:0] STB_LAST  = 32'(LOCK_STABLE_CYCLES - 1);
  localparam logic [31:0] GATE_LAST = 32'(GATE_DELAY - 1);
  localparam logic [7:0]  RETRY_MAX = 8'(MAX_RETRY);

  state_t      state, nxt_state;
  logic [31:0] timer, nxt_timer;
  logic [7:0]  nxt_retry;
  logic        lock_m, lock_s;

  always_ff @(posedge clkin1 or posedge ext_rst) begin
    if (ext_rst) begin
      lock_m <= 1'b0;
      lock_s <= 1'b0;
    end else begin
      lock_m <= pll_lock;
      lock_s <= lock_m;
    end
  end

  always_comb begin
    nxt_state = state;
    nxt_retry = retry_cnt;
    nxt_timer = timer + 32'd1;
    case (state)
      S_RESET:
        if (timer == RST_LAST) nxt_state = S_WAIT_LOCK;
      S_WAIT_LOCK:
        if (lock_s) begin
          nxt_state = S_STABLE;
        end else if (timer == TO_LAST) begin
          nxt_retry = retry_cnt + 8'd1;
          nxt_state = (nxt_retry == RETRY_MAX) ? S_FAULT : S_RESET;
        end
      S_STABLE:
        if (!lock_s) nxt_state = S_WAIT_LOCK;
        else if (timer == STB_LAST) nxt_state = S_GATE_DLY;
      S_GATE_DLY:
        if (!lock_s) nxt_state = S_RESET;
        else if (timer == GATE_LAST) nxt_state = S_RUN;
      S_RUN: begin
        nxt_timer = timer;
        if (!lock_s) nxt_state = S_RESET;
      end
      S_FAULT:
        nxt_timer = timer;
      default:
        nxt_state = S_RESET;
    endcase
    if (nxt_state == S_RUN && state != S_RUN) nxt_retry = 8'd0;
    // Soft reset wins over everything here; the lock-loss count is handled separately.
    if (soft_rst_req) begin
      nxt_state = S_RESET;
      nxt_retry = 8'd0;
    end
    if (nxt_state != state || soft_rst_req) nxt_timer = 32'd0;
  end

  // Outputs are decoded from the next state so they move on the transition edge.
  always_ff @(posedge clkin1 or posedge ext_rst) begin
    if (ext_rst) begin
      state        <= S_RESET;
      timer        <= 32'd0;
      retry_cnt    <= 8'd0;
      pll_rst      <= 1'b1;
      clkout0_gate <= 1'b0;
      sys_rst      <= 1'b1;
      pll_ready    <= 1'b0;
      pll_fault    <= 1'b0;
    end else begin
      state        <= nxt_state;
      timer        <= nxt_timer;
      retry_cnt    <= nxt_retry;
      pll_rst      <= (nxt_state == S_RESET) || (nxt_state == S_FAULT);
      clkout0_gate <= (nxt_state == S_GATE_DLY) || (nxt_state == S_RUN);
      sys_rst      <= (nxt_state != S_RUN);
      pll_ready    <= (nxt_state == S_RUN);
      pll_fault    <= (nxt_state == S_FAULT);
    end
  end

`ifdef PLL_LOCK_MGR_LOSS_CNT_EN
  logic loss_inc;
  assign loss_inc = (state == S_RUN) && !lock_s;

  always_ff @(posedge clkin1 or posedge ext_rst) begin
    if (ext_rst) lock_loss_cnt <= 8'd0;
    else if (loss_inc && lock_loss_cnt != 8'hFF) lock_loss_cnt <= lock_loss_cnt + 8'd1;
  end
`else
  assign lock_loss_cnt = 8'd0;
`endif

endmodule
